// File: rtl/header_parser_if.sv
// Bundle of start/result/table-programming signals between the header parser and its host.
// PARSER_STATS_EN adds the packet and error counter outputs.
interface header_parser_if #(
    parameter int HDR_MAX_LEN = 64,
    parameter int NUM_HEADERS = 16
);
    logic                              start_i;
    logic [HDR_MAX_LEN-1:0][7:0]       pkt_hdr_i;
    logic                              ready_o;
    logic [NUM_HEADERS-1:0][31:0]      parsed_hdrs_o;
    logic [NUM_HEADERS-1:0]            hdr_valid_o;
    logic                              error_o;
    logic                              mod_hdr_we_i;
    logic [3:0]                        mod_hdr_id_i;
    logic [5:0]                        mod_hdr_len_i;
    logic [5:0]                        mod_nxt_off_i;
    logic [1:0]                        mod_nxt_len_i;
    logic                              mod_rule_we_i;
    logic [3:0]                        mod_rule_idx_i;
    logic                              mod_rule_valid_i;
    logic [3:0]                        mod_rule_cur_i;
    logic [15:0]                       mod_rule_val_i;
    logic [3:0]                        mod_rule_next_i;
`ifdef PARSER_STATS_EN
    logic [31:0]                       pkt_cnt_o;
    logic [31:0]                       err_cnt_o;
`endif

    modport master (
        output start_i, pkt_hdr_i,
        output mod_hdr_we_i, mod_hdr_id_i, mod_hdr_len_i, mod_nxt_off_i, mod_nxt_len_i,
        output mod_rule_we_i, mod_rule_idx_i, mod_rule_valid_i, mod_rule_cur_i,
        output mod_rule_val_i, mod_rule_next_i,
`ifdef PARSER_STATS_EN
        input  pkt_cnt_o, err_cnt_o,
`endif
        input  ready_o, parsed_hdrs_o, hdr_valid_o, error_o
    );

    modport slave (
        input  start_i, pkt_hdr_i,
        input  mod_hdr_we_i, mod_hdr_id_i, mod_hdr_len_i, mod_nxt_off_i, mod_nxt_len_i,
        input  mod_rule_we_i, mod_rule_idx_i, mod_rule_valid_i, mod_rule_cur_i,
        input  mod_rule_val_i, mod_rule_next_i,
`ifdef PARSER_STATS_EN
        output pkt_cnt_o, err_cnt_o,
`endif
        output ready_o, parsed_hdrs_o, hdr_valid_o, error_o
    );
endinterface

// File: rtl/header_parser.sv
// Programmable parse-graph walker: records the byte offset of each recognised header, one header per cycle.
// Optional feature macro: PARSER_STATS_EN (packet/error counters).
module header_parser #(
    parameter int HDR_MAX_LEN = 64,
    parameter int NUM_HEADERS = 16,
    parameter int NUM_RULES   = 16
) (
    input logic           clk,
    input logic           rst,
    header_parser_if.slave bus
);
    typedef enum logic [1:0] {FREE, PARSE, DONE} state_t;

    state_t      state;
    logic [3:0]  cur_id;
    logic [31:0] cur_off;

    logic [5:0]  hdr_len     [NUM_HEADERS];
    logic [5:0]  hdr_nxt_off [NUM_HEADERS];
    logic [1:0]  hdr_nxt_len [NUM_HEADERS];

    logic        rule_valid  [NUM_RULES];
    logic [3:0]  rule_cur    [NUM_RULES];
    logic [15:0] rule_val    [NUM_RULES];
    logic [3:0]  rule_next   [NUM_RULES];

    logic [31:0] end_off;
    logic [31:0] field_off;
    logic [31:0] field_end;
    logic        wide;
    logic [7:0]  byte_hi;
    logic [7:0]  byte_lo;
    logic [15:0] field_val;
    logic        hit;
    logic [3:0]  hit_next;
    logic        truncated;
    logic        field_bad;
    logic        loop;

    // Evaluate the current header: bounds, next-type field and the winning rule
    always_comb begin
        end_off   = cur_off + 32'(hdr_len[cur_id]);
        wide      = hdr_nxt_len[cur_id][1];
        field_off = cur_off + 32'(hdr_nxt_off[cur_id]);
        field_end = field_off + (wide ? 32'd2 : 32'd1);
        byte_hi   = 8'h00;
        byte_lo   = 8'h00;
        for (int i = 0; i < HDR_MAX_LEN; i++) begin
            if (32'(i) == field_off)         byte_hi = bus.pkt_hdr_i[i];
            if (32'(i) == field_off + 32'd1) byte_lo = bus.pkt_hdr_i[i];
        end
        field_val = wide ? {byte_hi, byte_lo} : {8'h00, byte_hi};
        hit      = 1'b0;
        hit_next = 4'd0;
        // Descending scan so the lowest matching index is the one left standing
        for (int r = NUM_RULES - 1; r >= 0; r--) begin
            if (rule_valid[r] && rule_cur[r] == cur_id && rule_val[r] == field_val) begin
                hit      = 1'b1;
                hit_next = rule_next[r];
            end
        end
        truncated = (hdr_len[cur_id] == 6'd0) || (end_off > 32'(HDR_MAX_LEN));
        field_bad = field_end > 32'(HDR_MAX_LEN);
        // The header being recorded this cycle is not yet visible in hdr_valid_o
        loop      = bus.hdr_valid_o[hit_next] || (hit_next == cur_id);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= FREE;
            cur_id            <= 4'd0;
            cur_off           <= 32'd0;
            bus.ready_o       <= 1'b0;
            bus.error_o       <= 1'b0;
            bus.hdr_valid_o   <= '0;
            bus.parsed_hdrs_o <= '0;
            for (int h = 0; h < NUM_HEADERS; h++) begin
                hdr_len[h]     <= 6'd0;
                hdr_nxt_off[h] <= 6'd0;
                hdr_nxt_len[h] <= 2'd0;
            end
            for (int r = 0; r < NUM_RULES; r++) begin
                rule_valid[r] <= 1'b0;
                rule_cur[r]   <= 4'd0;
                rule_val[r]   <= 16'd0;
                rule_next[r]  <= 4'd0;
            end
`ifdef PARSER_STATS_EN
            bus.pkt_cnt_o <= 32'd0;
            bus.err_cnt_o <= 32'd0;
`endif
        end else begin
            bus.ready_o <= 1'b0;
            case (state)
                FREE: begin
                    if (bus.mod_hdr_we_i) begin
                        hdr_len[bus.mod_hdr_id_i]     <= bus.mod_hdr_len_i;
                        hdr_nxt_off[bus.mod_hdr_id_i] <= bus.mod_nxt_off_i;
                        hdr_nxt_len[bus.mod_hdr_id_i] <= bus.mod_nxt_len_i;
                    end
                    if (bus.mod_rule_we_i) begin
                        rule_valid[bus.mod_rule_idx_i] <= bus.mod_rule_valid_i;
                        rule_cur[bus.mod_rule_idx_i]   <= bus.mod_rule_cur_i;
                        rule_val[bus.mod_rule_idx_i]   <= bus.mod_rule_val_i;
                        rule_next[bus.mod_rule_idx_i]  <= bus.mod_rule_next_i;
                    end
                    if (bus.start_i && !bus.mod_hdr_we_i && !bus.mod_rule_we_i) begin
                        bus.error_o       <= 1'b0;
                        bus.hdr_valid_o   <= '0;
                        bus.parsed_hdrs_o <= '0;
                        cur_id            <= 4'd0;
                        cur_off           <= 32'd0;
                        state             <= PARSE;
                    end
                end
                PARSE: begin
                    if (truncated) begin
                        bus.error_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        bus.parsed_hdrs_o[cur_id] <= cur_off;
                        bus.hdr_valid_o[cur_id]   <= 1'b1;
                        if (hdr_nxt_len[cur_id] == 2'd0) begin
                            state <= DONE;
                        end else if (field_bad) begin
                            bus.error_o <= 1'b1;
                            state       <= DONE;
                        end else if (!hit) begin
                            state <= DONE;
                        end else if (loop) begin
                            bus.error_o <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cur_id  <= hit_next;
                            cur_off <= end_off;
                        end
                    end
                end
                DONE: begin
                    bus.ready_o <= 1'b1;
                    state       <= FREE;
`ifdef PARSER_STATS_EN
                    bus.pkt_cnt_o <= bus.pkt_cnt_o + 32'd1;
                    if (bus.error_o) bus.err_cnt_o <= bus.err_cnt_o + 32'd1;
`endif
                end
                default: state <= FREE;
            endcase
        end
    end
endmodule

// File: tb/tb_header_parser.sv
// Directed bench for header_parser: expected results queued at start, compared when ready_o pulses.
// Counter checks compile in when PARSER_STATS_EN is defined.
module tb_header_parser;
    localparam int HL = 64;
    localparam int NH = 16;

    typedef struct packed {
        logic [NH-1:0]       valid;
        logic                err;
        logic [NH-1:0][31:0] offs;
        logic [7:0]          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    header_parser_if #(.HDR_MAX_LEN(HL), .NUM_HEADERS(NH)) bus ();

    header_parser #(.HDR_MAX_LEN(HL), .NUM_HEADERS(NH), .NUM_RULES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] exp_pkt   = 32'd0;
    logic [31:0] exp_err   = 32'd0;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic doReset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        exp_pkt = 32'd0;
        exp_err = 32'd0;
    endtask

    task automatic wrHdr(input logic [3:0] id, input logic [5:0] len, input logic [5:0] off, input logic [1:0] w);
        @(negedge clk);
        bus.mod_hdr_we_i  = 1'b1;
        bus.mod_hdr_id_i  = id;
        bus.mod_hdr_len_i = len;
        bus.mod_nxt_off_i = off;
        bus.mod_nxt_len_i = w;
        @(negedge clk) bus.mod_hdr_we_i = 1'b0;
    endtask

    task automatic wrRule(input logic [3:0] idx, input logic v, input logic [3:0] cur,
                          input logic [15:0] val, input logic [3:0] nxt);
        @(negedge clk);
        bus.mod_rule_we_i    = 1'b1;
        bus.mod_rule_idx_i   = idx;
        bus.mod_rule_valid_i = v;
        bus.mod_rule_cur_i   = cur;
        bus.mod_rule_val_i   = val;
        bus.mod_rule_next_i  = nxt;
        @(negedge clk) bus.mod_rule_we_i = 1'b0;
    endtask

    task automatic setPkt(input logic [15:0] ethertype, input logic [7:0] proto);
        for (int i = 0; i < HL; i++) bus.pkt_hdr_i[i] = 8'($urandom);
        bus.pkt_hdr_i[12] = ethertype[15:8];
        bus.pkt_hdr_i[13] = ethertype[7:0];
        bus.pkt_hdr_i[23] = proto;
    endtask

    task automatic programEth();
        wrHdr(4'd0, 6'd14, 6'd12, 2'd2);
        wrHdr(4'd1, 6'd20, 6'd9, 2'd1);
        wrHdr(4'd2, 6'd20, 6'd0, 2'd0);
        wrRule(4'd0, 1'b1, 4'd0, 16'h0800, 4'd1);
        wrRule(4'd1, 1'b1, 4'd1, 16'h0006, 4'd2);
    endtask

    task automatic applyStimulus(input logic [NH-1:0] valid, input logic err,
                                 input logic [31:0] o1, input logic [31:0] o2, input logic [7:0] lat);
        exp_t e;
        e         = '0;
        e.valid   = valid;
        e.err     = err;
        e.offs[1] = o1;
        e.offs[2] = o2;
        e.lat     = lat;
        sb.push_back(e);
        @(negedge clk) bus.start_i = 1'b1;
        @(negedge clk) bus.start_i = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        int   lat_obs = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.ready_o && lat_obs == 0) lat_obs = k;
            if (lat_obs != 0) break;
        end
        checkValue({tag, "_ready_seen"}, 32'(lat_obs != 0), 32'd1);
        if (sb.size() == 0) begin
            checkValue({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        exp_pkt = exp_pkt + 32'd1;
        if (e.err) exp_err = exp_err + 32'd1;
        checkValue({tag, "_latency"}, 32'(lat_obs), 32'(e.lat));
        checkValue({tag, "_hdr_valid"}, 32'(bus.hdr_valid_o), 32'(e.valid));
        checkValue({tag, "_error"}, 32'(bus.error_o), 32'(e.err));
        for (int i = 0; i < NH; i++)
            checkValue($sformatf("%s_off%0d", tag, i), bus.parsed_hdrs_o[i], e.offs[i]);
`ifdef PARSER_STATS_EN
        checkValue({tag, "_pkt_cnt"}, bus.pkt_cnt_o, exp_pkt);
        checkValue({tag, "_err_cnt"}, bus.err_cnt_o, exp_err);
`endif
        @(negedge clk);
        checkValue({tag, "_ready_pulse_end"}, 32'(bus.ready_o), 32'd0);
    endtask

    task automatic checkIdle(input string tag);
        checkValue({tag, "_ready"}, 32'(bus.ready_o), 32'd0);
        checkValue({tag, "_error"}, 32'(bus.error_o), 32'd0);
        checkValue({tag, "_hdr_valid"}, 32'(bus.hdr_valid_o), 32'd0);
        for (int i = 0; i < NH; i++)
            checkValue($sformatf("%s_off%0d", tag, i), bus.parsed_hdrs_o[i], 32'd0);
    endtask

    initial begin
        int seen;
        bus.start_i          = 1'b0;
        bus.mod_hdr_we_i     = 1'b0;
        bus.mod_hdr_id_i     = 4'd0;
        bus.mod_hdr_len_i    = 6'd0;
        bus.mod_nxt_off_i    = 6'd0;
        bus.mod_nxt_len_i    = 2'd0;
        bus.mod_rule_we_i    = 1'b0;
        bus.mod_rule_idx_i   = 4'd0;
        bus.mod_rule_valid_i = 1'b0;
        bus.mod_rule_cur_i   = 4'd0;
        bus.mod_rule_val_i   = 16'd0;
        bus.mod_rule_next_i  = 4'd0;
        setPkt(16'h0800, 8'd6);

        doReset();
        checkIdle("reset");
`ifdef PARSER_STATS_EN
        checkValue("reset_pkt_cnt", bus.pkt_cnt_o, 32'd0);
        checkValue("reset_err_cnt", bus.err_cnt_o, 32'd0);
`endif

        applyStimulus(16'h0000, 1'b1, 32'd0, 32'd0, 8'd2);
        checkOutput("empty_tables");

        programEth();
        setPkt(16'h0800, 8'd6);
        applyStimulus(16'h0007, 1'b0, 32'd14, 32'd34, 8'd4);
        checkOutput("eth_ipv4_tcp");

        setPkt(16'h86DD, 8'd6);
        applyStimulus(16'h0001, 1'b0, 32'd0, 32'd0, 8'd2);
        checkOutput("unknown_ethertype");

        wrHdr(4'd1, 6'd60, 6'd9, 2'd1);
        setPkt(16'h0800, 8'd6);
        applyStimulus(16'h0001, 1'b1, 32'd0, 32'd0, 8'd3);
        checkOutput("truncation");
        wrHdr(4'd1, 6'd20, 6'd9, 2'd1);

        wrRule(4'd3, 1'b1, 4'd0, 16'h0800, 4'd2);
        applyStimulus(16'h0007, 1'b0, 32'd14, 32'd34, 8'd4);
        checkOutput("priority");

        wrRule(4'd1, 1'b1, 4'd1, 16'h0006, 4'd0);
        applyStimulus(16'h0003, 1'b1, 32'd14, 32'd0, 8'd3);
        checkOutput("loop");

        // A table write in the same cycle as start_i must swallow the start
        @(negedge clk);
        bus.start_i       = 1'b1;
        bus.mod_rule_we_i = 1'b1;
        @(negedge clk);
        bus.start_i       = 1'b0;
        bus.mod_rule_we_i = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.ready_o) seen = 1;
        end
        checkValue("write_beats_start", 32'(seen), 32'd0);

        wrRule(4'd1, 1'b1, 4'd1, 16'h0006, 4'd2);
        @(negedge clk) bus.start_i = 1'b1;
        @(negedge clk) bus.start_i = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        exp_pkt = 32'd0;
        exp_err = 32'd0;
        checkIdle("mid_reset");
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.ready_o) seen = 1;
        end
        checkValue("mid_reset_no_ready", 32'(seen), 32'd0);
        applyStimulus(16'h0000, 1'b1, 32'd0, 32'd0, 8'd2);
        checkOutput("after_reset_cleared");

        wrHdr(4'd0, 6'd14, 6'd63, 2'd2);
        applyStimulus(16'h0001, 1'b1, 32'd0, 32'd0, 8'd2);
        checkOutput("field_past_end");

        doReset();
        programEth();
        setPkt(16'h0800, 8'd6);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(16'h0007, 1'b0, 32'd14, 32'd34, 8'd4);
            checkOutput($sformatf("stats_good%0d", p));
        end
        wrHdr(4'd1, 6'd60, 6'd9, 2'd1);
        applyStimulus(16'h0001, 1'b1, 32'd0, 32'd0, 8'd3);
        checkOutput("stats_trunc");
`ifdef PARSER_STATS_EN
        checkValue("stats_final_pkt", bus.pkt_cnt_o, 32'd4);
        checkValue("stats_final_err", bus.err_cnt_o, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
